wb_queue: RTL and testbench

Writeback buffer sitting directly upstream of the register file write ports. It accepts up to two results per cycle from execute/memory, queues them in order in a small FIFO, and drains up to two per cycle onto the register file's two write ports (w_enable1/addr1/d1writeback, w_enable2/addr2/d2writeback). It exports a per-register pending mask so decode can stall on registers with queued writes.

---
 rtl/wb_queue.sv | 109 ++++++++++
 tb/tb_wb_queue.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_queue.sv
// Writeback queue in front of the two register file write ports. It accepts up to two
// results per cycle, keeps them in order, drains up to two per cycle, and exports a pending mask.
module wb_queue #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid1,
    input  logic [ADDR_W-1:0]         in_addr1,
    input  logic [DATA_W-1:0]         in_data1,
    input  logic                      in_valid2,
    input  logic [ADDR_W-1:0]         in_addr2,
    input  logic [DATA_W-1:0]         in_data2,
    output logic                      in_ready,
    output logic                      w_enable1,
    output logic [ADDR_W-1:0]         addr1,
    output logic [DATA_W-1:0]         d1writeback,
    output logic                      w_enable2,
    output logic [ADDR_W-1:0]         addr2,
    output logic [DATA_W-1:0]         d2writeback,
    output logic [(1<<ADDR_W)-1:0]    pending,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      overflow
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_W-1:0] r_addr [DEPTH];
    logic [DATA_W-1:0] r_data [DEPTH];
    logic [PW-1:0]     r_head;
    logic [PW-1:0]     r_tail;
    logic [CW-1:0]     r_count;

    logic [PW-1:0]     w_head1;
    logic [PW-1:0]     w_tail1;
    logic [PW-1:0]     w_slot2;
    logic              w_pop2;
    logic [1:0]        w_npop;
    logic [1:0]        w_nenq;
    logic [(1<<ADDR_W)-1:0] w_pending;

    assign w_head1  = r_head + 1'b1;
    assign w_tail1  = r_tail + 1'b1;
    assign w_slot2  = in_valid1 ? w_tail1 : r_tail;
    assign in_ready = (CW'(DEPTH) - r_count) >= CW'(2);
    assign count    = r_count;
    assign pending  = w_pending;

    // Two queued writes to the same register never share a drain cycle, so the younger one lands last.
    assign w_pop2 = (r_count >= CW'(2)) && (r_addr[r_head] != r_addr[w_head1]);
    assign w_npop = (r_count == '0) ? 2'd0 : (w_pop2 ? 2'd2 : 2'd1);
    assign w_nenq = in_ready ? ({1'b0, in_valid1} + {1'b0, in_valid2}) : 2'd0;

    always_comb begin
        w_pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) < r_count) begin
                w_pending[r_addr[r_head + PW'(i)]] = 1'b1;
            end
        end
        if (w_enable1) w_pending[addr1] = 1'b1;
        if (w_enable2) w_pending[addr2] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (in_ready) begin
            if (in_valid1) begin
                r_addr[r_tail] <= in_addr1;
                r_data[r_tail] <= in_data1;
            end
            if (in_valid2) begin
                r_addr[w_slot2] <= in_addr2;
                r_data[w_slot2] <= in_data2;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            w_enable1   <= 1'b0;
            w_enable2   <= 1'b0;
            addr1       <= '0;
            addr2       <= '0;
            d1writeback <= '0;
            d2writeback <= '0;
            overflow    <= 1'b0;
        end else begin
            w_enable1 <= (r_count != '0);
            w_enable2 <= w_pop2;
            if (r_count != '0) begin
                addr1       <= r_addr[r_head];
                d1writeback <= r_data[r_head];
            end
            if (w_pop2) begin
                addr2       <= r_addr[w_head1];
                d2writeback <= r_data[w_head1];
            end
            r_head  <= r_head + PW'(w_npop);
            r_tail  <= r_tail + PW'(w_nenq);
            r_count <= r_count + CW'(w_nenq) - CW'(w_npop);
            if (!in_ready && (in_valid1 || in_valid2)) overflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_wb_queue.sv
// Bench for wb_queue: an ordered scoreboard of expected register writes predicts the write
// ports, occupancy, pending mask and overflow each cycle; table vectors plus corner-case sequences.
module tb_wb_queue;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid1 = 1'b0, in_valid2 = 1'b0;
    logic [3:0]  in_addr1 = '0, in_addr2 = '0;
    logic [15:0] in_data1 = '0, in_data2 = '0;
    logic        in_ready, w_enable1, w_enable2, overflow;
    logic [3:0]  addr1, addr2;
    logic [15:0] d1writeback, d2writeback, pending;
    logic [2:0]  count;

    wb_queue #(.DATA_W(16), .ADDR_W(4), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .in_valid1(in_valid1), .in_addr1(in_addr1), .in_data1(in_data1),
        .in_valid2(in_valid2), .in_addr2(in_addr2), .in_data2(in_data2),
        .in_ready(in_ready),
        .w_enable1(w_enable1), .addr1(addr1), .d1writeback(d1writeback),
        .w_enable2(w_enable2), .addr2(addr2), .d2writeback(d2writeback),
        .pending(pending), .count(count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Register file stub committing whatever the write ports carry
    logic [15:0] rf [16];
    int          wr_hi = 0;
    always @(posedge clk) begin
        if (w_enable1) rf[addr1] <= d1writeback;
        if (w_enable2) rf[addr2] <= d2writeback;
        if ((w_enable1 && (addr1 == 4'd13 || addr1 == 4'd14)) ||
            (w_enable2 && (addr2 == 4'd13 || addr2 == 4'd14)))
            wr_hi <= wr_hi + 1;
    end

    typedef struct {
        logic [3:0]  addr;
        logic [15:0] data;
    } wr_t;

    typedef struct {
        logic        v1;
        logic [3:0]  a1;
        logic [15:0] d1;
        logic        v2;
        logic [3:0]  a2;
        logic [15:0] d2;
        int          exp_cnt;
    } vec_t;

    wr_t  sb[$];
    vec_t vecs[10];
    int   checks = 0;
    int   errors = 0;
    logic e_en1 = 0, e_en2 = 0, e_ovf = 0;
    logic [3:0]  e_a1 = '0, e_a2 = '0;
    logic [15:0] e_d1 = '0, e_d2 = '0;
    logic seen_not_ready = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] pend_model();
        logic [15:0] p = '0;
        foreach (sb[i]) p[sb[i].addr] = 1'b1;
        if (e_en1) p[e_a1] = 1'b1;
        if (e_en2) p[e_a2] = 1'b1;
        return p;
    endfunction

    // One clock cycle: called at a falling edge, predicts the next rising edge, checks after it.
    task automatic cycle(input logic v1, input logic [3:0] a1, input logic [15:0] d1,
                         input logic v2, input logic [3:0] a2, input logic [15:0] d2);
        int   n;
        logic rdy;
        n   = sb.size();
        rdy = (DEPTH - n) >= 2;
        chk("in_ready", in_ready, rdy);
        if (!in_ready) seen_not_ready = 1;
        if (n >= 2 && sb[0].addr != sb[1].addr) begin
            e_en1 = 1; e_a1 = sb[0].addr; e_d1 = sb[0].data;
            e_en2 = 1; e_a2 = sb[1].addr; e_d2 = sb[1].data;
            void'(sb.pop_front());
            void'(sb.pop_front());
        end else if (n >= 1) begin
            e_en1 = 1; e_a1 = sb[0].addr; e_d1 = sb[0].data;
            e_en2 = 0;
            void'(sb.pop_front());
        end else begin
            e_en1 = 0;
            e_en2 = 0;
        end
        if (rdy) begin
            if (v1) sb.push_back('{addr: a1, data: d1});
            if (v2) sb.push_back('{addr: a2, data: d2});
        end else if (v1 || v2) begin
            e_ovf = 1;
        end
        in_valid1 = v1; in_addr1 = a1; in_data1 = d1;
        in_valid2 = v2; in_addr2 = a2; in_data2 = d2;
        @(posedge clk);
        #1;
        in_valid1 = 0; in_valid2 = 0;
        @(negedge clk);
        chk("w_enable1", w_enable1, e_en1);
        chk("w_enable2", w_enable2, e_en2);
        chk("addr1", addr1, e_a1);
        chk("d1writeback", d1writeback, e_d1);
        chk("addr2", addr2, e_a2);
        chk("d2writeback", d2writeback, e_d2);
        chk("count", count, sb.size());
        chk("pending", pending, pend_model());
        chk("overflow", overflow, e_ovf);
        if (w_enable1 && w_enable2) chk("port_addr_distinct", (addr1 != addr2), 1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        vecs[0] = '{1'b1, 4'h1, 16'h0101, 1'b1, 4'h2, 16'h0202, 2};
        vecs[1] = '{1'b1, 4'h4, 16'h0404, 1'b0, 4'h0, 16'h0000, 1};
        vecs[2] = '{1'b0, 4'h0, 16'h0000, 1'b0, 4'h0, 16'h0000, 0};
        vecs[3] = '{1'b1, 4'h6, 16'h6A6A, 1'b1, 4'h6, 16'h6B6B, 2};
        vecs[4] = '{1'b1, 4'h7, 16'h0707, 1'b1, 4'h8, 16'h0808, 3};
        vecs[5] = '{1'b0, 4'h0, 16'h0000, 1'b0, 4'h0, 16'h0000, 1};
        vecs[6] = '{1'b0, 4'h0, 16'h0000, 1'b0, 4'h0, 16'h0000, 0};
        vecs[7] = '{1'b0, 4'h0, 16'h0000, 1'b1, 4'h5, 16'h00FF, 1};
        vecs[8] = '{1'b0, 4'h0, 16'h0000, 1'b0, 4'h0, 16'h0000, 0};
        vecs[9] = '{1'b0, 4'h0, 16'h0000, 1'b0, 4'h0, 16'h0000, 0};

        // Reset, then idle
        rst = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_w_enable1", w_enable1, 0);
        chk("rst_w_enable2", w_enable2, 0);
        chk("rst_addr1", addr1, 0);
        chk("rst_addr2", addr2, 0);
        chk("rst_d1", d1writeback, 0);
        chk("rst_d2", d2writeback, 0);
        chk("rst_count", count, 0);
        chk("rst_pending", pending, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_in_ready", in_ready, 1);
        rst = 0;
        idle(5);

        // Dual enqueue to distinct registers
        cycle(1, 4'hA, 16'h1A1A, 1, 4'hC, 16'h2BC3);
        chk("dual_pend_enq", {pending[10], pending[12]}, 2'b11);
        idle(1);
        chk("dual_en1", w_enable1, 1);
        chk("dual_addr1", addr1, 4'hA);
        chk("dual_d1", d1writeback, 16'h1A1A);
        chk("dual_en2", w_enable2, 1);
        chk("dual_addr2", addr2, 4'hC);
        chk("dual_d2", d2writeback, 16'h2BC3);
        chk("dual_pend_port", {pending[10], pending[12]}, 2'b11);
        idle(1);
        chk("dual_pend_clear", {pending[10], pending[12]}, 2'b00);

        // Same register in both slots: ordered over two cycles
        cycle(1, 4'h3, 16'h1111, 1, 4'h3, 16'h2222);
        idle(1);
        chk("same_first_d1", d1writeback, 16'h1111);
        chk("same_first_en2", w_enable2, 0);
        idle(1);
        chk("same_second_en1", w_enable1, 1);
        chk("same_second_d1", d1writeback, 16'h2222);
        idle(1);
        chk("same_rf_r3", rf[3], 16'h2222);

        // Table vectors
        for (int i = 0; i < 10; i++) begin
            cycle(vecs[i].v1, vecs[i].a1, vecs[i].d1, vecs[i].v2, vecs[i].a2, vecs[i].d2);
            chk($sformatf("tbl_count_%0d", i), count, vecs[i].exp_cnt);
        end

        // Single slot-2 input goes out on port 1
        cycle(0, 0, 0, 1, 4'h5, 16'h00FF);
        idle(1);
        chk("single_en1", w_enable1, 1);
        chk("single_addr1", addr1, 4'h5);
        chk("single_d1", d1writeback, 16'h00FF);
        chk("single_en2", w_enable2, 0);
        idle(2);

        // Flood one register from both slots: queue fills, inputs get dropped
        for (int i = 0; i < 6; i++) begin
            cycle(1, 4'h7, 16'h7000 + 16'(2*i), 1, 4'h7, 16'h7001 + 16'(2*i));
            chk("fill_count_bound", (count <= 3'(DEPTH)), 1);
        end
        chk("fill_saw_not_ready", seen_not_ready, 1);
        chk("fill_overflow", overflow, 1);
        idle(6);
        chk("fill_overflow_sticky", overflow, 1);
        chk("fill_rf_r7_last_kept", rf[7], 16'h700B);

        // Reset while entries are still queued
        cycle(1, 4'hD, 16'hAAAA, 1, 4'hD, 16'hBBBB);
        cycle(1, 4'hE, 16'hCCCC, 1, 4'hE, 16'hDDDD);
        #2 rst = 1;
        #1;
        chk("mid_rst_en1", w_enable1, 0);
        chk("mid_rst_en2", w_enable2, 0);
        chk("mid_rst_count", count, 0);
        chk("mid_rst_pending", pending, 0);
        chk("mid_rst_overflow", overflow, 0);
        sb.delete();
        e_en1 = 0; e_en2 = 0; e_ovf = 0;
        e_a1 = '0; e_a2 = '0; e_d1 = '0; e_d2 = '0;
        @(negedge clk);
        rst = 0;
        idle(4);
        chk("mid_rst_no_writes", wr_hi, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
